// File: rtl/usb_rx_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : usb_rx_capture
//  Description : Frames packets received on the UTMI interface into capture
//                records (4-byte header {type, error, trunc, len[10:0],
//                ts[17:0]}, sent MSB first, followed by the packet bytes) and
//                streams them out on an 8-bit valid/ready interface. Packet
//                bytes and headers are buffered in separate FIFOs so that a
//                stalling consumer does not disturb bus-rate reception.
//  Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//                utmi_rx_*_i             - UTMI receive interface from the PHY
//                utmi_linestate_i        - UTMI line state
//                enable_i                - capture enable, sampled at packet start
//                out_data_o/out_valid_o/out_ready_i - record byte stream
//                drop_count_o            - saturating count of dropped packets
//  Options     : USB_RX_CAPTURE_LINESTATE_EN - emit type=1 line-state event
//                records when the idle line state changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_capture #(
    parameter int DATA_AW = 11,
    parameter int HDR_AW  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  utmi_rx_data_i,
    input  logic        utmi_rx_active_i,
    input  logic        utmi_rx_valid_i,
    input  logic        utmi_rx_error_i,
    input  logic [1:0]  utmi_linestate_i,
    input  logic        enable_i,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] drop_count_o
);

    localparam logic [1:0]    c_ST_IDLE = 2'd0;
    localparam logic [1:0]    c_ST_HDR  = 2'd1;
    localparam logic [1:0]    c_ST_DATA = 2'd2;
    localparam logic [10:0]   c_MAX_LEN = 11'd2047;
    localparam logic [DATA_AW:0] c_DPTR_ONE = {{DATA_AW{1'b0}}, 1'b1};
    localparam logic [HDR_AW:0]  c_HPTR_ONE = {{HDR_AW{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Storage: pointers carry one extra wrap bit so full/empty are exact
    // and every entry is usable.
    // ------------------------------------------------------------------
    logic [7:0]         r_dmem [0:(1<<DATA_AW)-1];
    logic [DATA_AW:0]   r_dwr, r_drd;
    logic [31:0]        r_hmem [0:(1<<HDR_AW)-1];
    logic [HDR_AW:0]    r_hwr, r_hrd;

    logic w_dfull, w_hfull, w_hempty;
    assign w_dfull  = (r_dwr[DATA_AW] != r_drd[DATA_AW]) &&
                      (r_dwr[DATA_AW-1:0] == r_drd[DATA_AW-1:0]);
    assign w_hfull  = (r_hwr[HDR_AW] != r_hrd[HDR_AW]) &&
                      (r_hwr[HDR_AW-1:0] == r_hrd[HDR_AW-1:0]);
    assign w_hempty = (r_hwr == r_hrd);

    // ------------------------------------------------------------------
    // Capture side
    // ------------------------------------------------------------------
    logic [17:0] r_ts, r_ts_lat;
    logic        r_active_d, r_in_pkt, r_err, r_trunc;
    logic [10:0] r_len;
    logic [15:0] r_drop_cnt;

    logic        w_start, w_start_ok, w_in, w_take, w_dwr, w_trunc_set, w_err_set, w_end;
    logic [10:0] w_len_base;
    logic [31:0] w_pkt_word, w_ev_word, w_hwdata;
    logic        w_ev, w_hpush;

    assign w_start     = utmi_rx_active_i & ~r_active_d;
    assign w_start_ok  = w_start & enable_i & ~w_hfull;
    // On the start cycle the accept decision is not yet registered.
    assign w_in        = w_start ? w_start_ok : r_in_pkt;
    assign w_take      = w_in & utmi_rx_active_i & utmi_rx_valid_i;
    assign w_len_base  = w_start ? 11'd0 : r_len;
    assign w_dwr       = w_take & (w_len_base < c_MAX_LEN) & ~w_dfull;
    assign w_trunc_set = w_take & ~w_dwr;
    assign w_err_set   = w_in & utmi_rx_active_i & utmi_rx_error_i;
    assign w_end       = r_in_pkt & r_active_d & ~utmi_rx_active_i;
    assign w_pkt_word  = {1'b0, r_err, r_trunc, r_len, r_ts_lat};

`ifdef USB_RX_CAPTURE_LINESTATE_EN
    logic [1:0] r_ls_last;
    // Uses the current line state, so a change held off by a full FIFO
    // naturally coalesces to the latest value.
    assign w_ev      = ~utmi_rx_active_i & ~w_end & ~w_hfull &
                       (utmi_linestate_i != r_ls_last);
    assign w_ev_word = {1'b1, utmi_linestate_i, 11'd0, r_ts};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ls_last <= 2'b00;
        end else if (w_ev) begin
            r_ls_last <= utmi_linestate_i;
        end
    end
`else
    logic w_unused_ls;
    assign w_unused_ls = ^utmi_linestate_i;
    assign w_ev        = 1'b0;
    assign w_ev_word   = 32'd0;
`endif

    // Packet-end header takes priority; a pending event retries next cycle.
    assign w_hpush  = (w_end & ~w_hfull) | w_ev;
    assign w_hwdata = w_end ? w_pkt_word : w_ev_word;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ts       <= 18'd0;
            r_ts_lat   <= 18'd0;
            r_active_d <= 1'b0;
            r_in_pkt   <= 1'b0;
            r_err      <= 1'b0;
            r_trunc    <= 1'b0;
            r_len      <= 11'd0;
            r_drop_cnt <= 16'd0;
            r_dwr      <= '0;
            r_hwr      <= '0;
        end else begin
            r_ts       <= r_ts + 18'd1;
            r_active_d <= utmi_rx_active_i;
            r_in_pkt   <= w_start ? w_start_ok : (r_in_pkt & utmi_rx_active_i);
            r_len      <= w_len_base + {10'd0, w_dwr};
            r_err      <= (w_start ? 1'b0 : r_err) | w_err_set;
            r_trunc    <= (w_start ? 1'b0 : r_trunc) | w_trunc_set;
            if (w_start) begin
                r_ts_lat <= r_ts;
            end
            if (w_start && !w_start_ok && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_dwr) begin
                r_dwr <= r_dwr + c_DPTR_ONE;
            end
            if (w_hpush) begin
                r_hwr <= r_hwr + c_HPTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_dwr) begin
            r_dmem[r_dwr[DATA_AW-1:0]] <= utmi_rx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hpush) begin
            r_hmem[r_hwr[HDR_AW-1:0]] <= w_hwdata;
        end
    end

    // ------------------------------------------------------------------
    // Output side. r_state names the source of the next byte to load into
    // the output register; loading happens whenever the register is empty
    // or being accepted, which keeps records back to back.
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic [23:0] r_shift;
    logic [1:0]  r_hcnt;
    logic [10:0] r_dcnt;
    logic        w_advance;
    logic [31:0] w_hrdata;

    assign w_advance = ~r_out_valid | out_ready_i;
    assign w_hrdata  = r_hmem[r_hrd[HDR_AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_shift     <= 24'd0;
            r_hcnt      <= 2'd0;
            r_dcnt      <= 11'd0;
            r_hrd       <= '0;
            r_drd       <= '0;
        end else if (w_advance) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_hempty) begin
                        r_hrd       <= r_hrd + c_HPTR_ONE;
                        r_out_data  <= w_hrdata[31:24];
                        r_out_valid <= 1'b1;
                        r_shift     <= w_hrdata[23:0];
                        r_hcnt      <= 2'd3;
                        // Event records (type=1) carry no payload.
                        r_dcnt      <= w_hrdata[31] ? 11'd0 : w_hrdata[28:18];
                        r_state     <= c_ST_HDR;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                c_ST_HDR: begin
                    r_out_data  <= r_shift[23:16];
                    r_out_valid <= 1'b1;
                    r_shift     <= {r_shift[15:0], 8'd0};
                    r_hcnt      <= r_hcnt - 2'd1;
                    if (r_hcnt == 2'd1) begin
                        r_state <= (r_dcnt != 11'd0) ? c_ST_DATA : c_ST_IDLE;
                    end
                end
                c_ST_DATA: begin
                    r_out_data  <= r_dmem[r_drd[DATA_AW-1:0]];
                    r_out_valid <= 1'b1;
                    r_drd       <= r_drd + c_DPTR_ONE;
                    r_dcnt      <= r_dcnt - 11'd1;
                    if (r_dcnt == 11'd1) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data_o   = r_out_data;
    assign out_valid_o  = r_out_valid;
    assign drop_count_o = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_usb_rx_capture
//  Description : Directed self-checking bench for usb_rx_capture. Drives UTMI
//                packets, collects the record byte stream and compares it
//                against hand-computed header words and payload bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_active = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_error = 1'b0;
    logic [1:0]  linestate = 2'b00;
    logic        enable = 1'b1;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] drop_count;

    usb_rx_capture dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .utmi_rx_data_i   (rx_data),
        .utmi_rx_active_i (rx_active),
        .utmi_rx_valid_i  (rx_valid),
        .utmi_rx_error_i  (rx_error),
        .utmi_linestate_i (linestate),
        .enable_i         (enable),
        .out_data_o       (out_data),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .drop_count_o     (drop_count)
    );

    always #5 clk = ~clk;

    // Reference cycle count since reset release (the expected timestamp base).
    int tb_cyc = 0;
    always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte collector plus stall-hold check, sampled on the falling edge.
    logic [7:0] got[$];
    int         got_t[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got_t.push_back(tb_cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    function automatic logic [7:0] getb(input int i);
        if (i < got.size()) return got[i];
        return 8'h00;
    endfunction

    function automatic logic [31:0] gword(input int i);
        return {getb(i), getb(i+1), getb(i+2), getb(i+3)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pb [0:2199];

    // One cycle of active without valid, n data cycles, then one idle cycle
    // (the packet-end cycle). Returns the timestamp the start should latch.
    task automatic send_pkt(input int n, input int err_at, output logic [17:0] ts_exp);
        int c;
        c = tb_cyc;
        ts_exp = c[17:0];
        rx_active = 1'b1;
        rx_valid  = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = pb[i];
            rx_error = (i == err_at);
            tick();
        end
        rx_valid  = 1'b0;
        rx_error  = 1'b0;
        rx_active = 1'b0;
        tick();
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget, input bit rnd);
        for (int c = 0; c < budget && got.size() < n; c++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        chk(tag, 32'(got.size()), 32'(n));
    endtask

    task automatic clear_got();
        got.delete();
        got_t.delete();
    endtask

    logic [17:0] ts, ts2;
    logic [17:0] ts_q [0:17];
    int          lat;

    initial begin
        // ---------------- reset ----------------
        repeat (3) tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);
        rst = 1'b0;

        // ---------------- packet A5 12 34 at ts=0x10 ----------------
        pb[0] = 8'hA5; pb[1] = 8'h12; pb[2] = 8'h34;
        while (tb_cyc != 16) tick();
        send_pkt(3, -1, ts);
        lat = 0;
        while (!out_valid && lat < 3) begin
            tick();
            lat++;
        end
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        wait_bytes("a_count", 7, 50, 1'b0);
        chk("a_hdr", gword(0), 32'h000C_0010);
        chk("a_d0", {24'd0, getb(4)}, 32'h0000_00A5);
        chk("a_d1", {24'd0, getb(5)}, 32'h0000_0012);
        chk("a_d2", {24'd0, getb(6)}, 32'h0000_0034);
        chk("a_drop", {16'd0, drop_count}, 32'd0);
        clear_got();

        // ---------------- same packet with an error pulse ----------------
        send_pkt(3, 1, ts);
        wait_bytes("err_count", 7, 50, 1'b0);
        chk("err_hdr", gword(0), {1'b0, 1'b1, 1'b0, 11'd3, ts});
        chk("err_d0", {24'd0, getb(4)}, 32'h0000_00A5);
        chk("err_d1", {24'd0, getb(5)}, 32'h0000_0012);
        chk("err_d2", {24'd0, getb(6)}, 32'h0000_0034);
        clear_got();

        // ---------------- 2100-byte packet: truncated at 2047 ----------------
        for (int i = 0; i < 2100; i++) pb[i] = 8'(i * 7 + 3);
        send_pkt(2100, -1, ts);
        wait_bytes("long_count", 4 + 2047, 3000, 1'b0);
        chk("long_hdr", gword(0), {1'b0, 1'b0, 1'b1, 11'd2047, ts});
        for (int i = 0; i < 2047; i++) chk("long_data", {24'd0, getb(4 + i)}, {24'd0, pb[i]});
        clear_got();

        // ---------------- zero-length packet ----------------
        send_pkt(0, -1, ts);
        wait_bytes("len0_count", 4, 50, 1'b0);
        chk("len0_hdr", gword(0), {14'd0, ts});
        repeat (10) tick();
        chk("len0_nodata", 32'(got.size()), 32'd4);
        clear_got();

        // ---------------- back-to-back packets, 1-cycle gap ----------------
        pb[0] = 8'h11; pb[1] = 8'h22;
        send_pkt(2, -1, ts);
        pb[0] = 8'h33; pb[1] = 8'h44;
        send_pkt(2, -1, ts2);
        wait_bytes("b2b_count", 12, 60, 1'b0);
        chk("b2b_hdr1", gword(0), {3'b000, 11'd2, ts});
        chk("b2b_d10", {24'd0, getb(4)}, 32'h11);
        chk("b2b_d11", {24'd0, getb(5)}, 32'h22);
        chk("b2b_hdr2", gword(6), {3'b000, 11'd2, ts2});
        chk("b2b_d20", {24'd0, getb(10)}, 32'h33);
        chk("b2b_d21", {24'd0, getb(11)}, 32'h44);
        chk("b2b_tsdiff", {14'd0, gword(6)[17:0] - gword(0)[17:0]}, 32'd4);
        chk("b2b_rate", 32'(got_t[11] - got_t[0]), 32'd11);
        clear_got();

        // ---------------- header FIFO overflow under stall ----------------
        // The first record moves into the output stage, so 16 more fit in the
        // header FIFO: packets 0..16 are kept and packet 17 is dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            pb[0] = 8'(8'h50 + k);
            send_pkt(1, -1, ts_q[k]);
        end
        chk("ovf_drop", {16'd0, drop_count}, 32'd1);
        chk("ovf_none_out", 32'(got.size()), 32'd0);
        wait_bytes("ovf_count", 17 * 5, 2000, 1'b1);
        for (int k = 0; k < 17; k++) begin
            chk("ovf_hdr", gword(5 * k), {3'b000, 11'd1, ts_q[k]});
            chk("ovf_data", {24'd0, getb(5 * k + 4)}, 32'(8'h50 + k));
        end
        clear_got();

        // ---------------- capture disabled ----------------
        enable = 1'b0;
        send_pkt(2, -1, ts);
        enable = 1'b1;
        repeat (10) tick();
        chk("dis_drop", {16'd0, drop_count}, 32'd2);
        chk("dis_none_out", 32'(got.size()), 32'd0);

        // ---------------- idle line-state change ----------------
`ifdef USB_RX_CAPTURE_LINESTATE_EN
        lat = tb_cyc;
        ts = lat[17:0];
        linestate = 2'b01;
        wait_bytes("ls_count", 4, 20, 1'b0);
        chk("ls_hdr", gword(0), {1'b1, 2'b01, 11'd0, ts});
        repeat (10) tick();
        chk("ls_nodata", 32'(got.size()), 32'd4);
`else
        linestate = 2'b01;
        repeat (3) tick();
        linestate = 2'b10;
        repeat (10) tick();
        chk("ls_no_event", 32'(got.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
